// File: rtl/pcap_replay_pkg.sv
// Shared definitions for the pcap capture/replay memory datapath:
// writer FSM states, burst-length constants and a constant-time ceil(log2).
package pcap_replay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } wr_state_e;

  localparam int BL2 = 2;
  localparam int BL4 = 4;

  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_to_mem_wbuf.sv
// Staging buffer between the capture FIFO and the write port: holds up to NW
// words, counts an in-flight pop as occupied, and presents the burst pair.
module fifo_to_mem_wbuf
  import pcap_replay_pkg::*;
#(
  parameter int DATA_W = 72,
  parameter int NW     = 1,
  localparam int CW    = log2(NW + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [CW-1:0]     occ,
  output logic [DATA_W-1:0] beat0,
  output logic [DATA_W-1:0] beat1
);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] words_q [NW];
  logic [DATA_W-1:0] words_d [NW];

  always_comb begin
    cnt_d      = cnt_q + CW'(inflight_q);
    inflight_d = pop;
    words_d    = words_q;
    if (inflight_q) begin
      for (int i = 0; i < NW; i++) begin
        if (cnt_q == CW'(i)) words_d[i] = din;
      end
    end
    if (clr) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    words_q <= words_d;
  end

  assign occ = cnt_q + CW'(inflight_q);

  // A word still arriving from the FIFO is taken straight from din.
  always_comb begin
    beat0 = (cnt_q != '0) ? words_q[0] : din;
    beat1 = din;
    if (NW > 1) begin
      if (cnt_q > CW'(1)) beat1 = words_q[NW-1];
    end
  end

endmodule

// File: rtl/fifo_to_mem.sv
// Capture writer: pops 72-bit words from the capture FIFO and writes them as
// sequential bursts into QDR-II SRAM. Define FIFO_TO_MEM_WRAP_EN for ring mode.
module fifo_to_mem
  import pcap_replay_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH  = 72,
  parameter int MEM_ADDR_WIDTH   = 19,
  parameter int MEM_DATA_WIDTH   = 36,
  parameter int MEM_BW_WIDTH     = 4,
  parameter int MEM_BURST_LENGTH = 2,
  parameter int MEM_ADDR_LOW     = 0,
  parameter int MEM_ADDR_HIGH    = MEM_ADDR_LOW + 2**MEM_ADDR_WIDTH / MEM_BURST_LENGTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sw_rst,
  input  logic                       cal_done,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  input  logic [FIFO_DATA_WIDTH-1:0] fifo_data,
  input  logic                       mem_wr_full,
  output logic                       mem_w_n,
  output logic [MEM_ADDR_WIDTH-1:0]  mem_ad_wr,
  output logic [MEM_DATA_WIDTH-1:0]  mem_dl,
  output logic [MEM_DATA_WIDTH-1:0]  mem_dh,
  output logic [MEM_BW_WIDTH-1:0]    mem_bw_n,
  output logic [MEM_ADDR_WIDTH:0]    wr_words,
  output logic                       mem_filled
);

  localparam int AW = MEM_ADDR_WIDTH;
  localparam int NW = (MEM_BURST_LENGTH == BL4) ? 2 : 1;
  localparam int CW = log2(NW + 1);
  localparam logic [AW-1:0] ADDR_LO = AW'(MEM_ADDR_LOW);
  localparam logic [AW-1:0] ADDR_HI = AW'(MEM_ADDR_HIGH);

  function automatic logic [AW:0] sat_add_nw(input logic [AW:0] v);
    logic [AW+1:0] s;
    s = {1'b0, v} + (AW+2)'(NW);
    return s[AW+1] ? '1 : s[AW:0];
  endfunction

  wr_state_e                state_q, state_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic                     mem_w_n_q, mem_w_n_d;
  logic [AW-1:0]            mem_ad_wr_q, mem_ad_wr_d;
  logic [MEM_DATA_WIDTH-1:0] mem_dl_q, mem_dl_d, mem_dh_q, mem_dh_d;
  logic [FIFO_DATA_WIDTH-1:0] beat1_q, beat1_d;
  logic                     beat1_pend_q, beat1_pend_d;
  logic [AW:0]              wr_words_q, wr_words_d;
  logic                     mem_filled_q, mem_filled_d;

  logic                       rst_any, go, issuing, issue;
  logic [CW-1:0]              occ;
  logic [FIFO_DATA_WIDTH-1:0] buf_beat0, buf_beat1;

  assign rst_any = rst | sw_rst;
  assign go      = (state_q == ST_RUN) && cal_done;
  // A command cycle or a BL4 second beat blocks popping so occupancy never exceeds NW.
  assign issuing = !mem_w_n_q || beat1_pend_q;
  assign issue   = go && (occ == CW'(NW)) && !mem_wr_full && !issuing;
  assign fifo_rd_en = go && !fifo_empty && (occ < CW'(NW)) && !issuing && !rst_any;

  fifo_to_mem_wbuf #(
    .DATA_W(FIFO_DATA_WIDTH),
    .NW    (NW)
  ) u_wbuf (
    .clk  (clk),
    .rst  (rst_any),
    .clr  (issue),
    .pop  (fifo_rd_en),
    .din  (fifo_data),
    .occ  (occ),
    .beat0(buf_beat0),
    .beat1(buf_beat1)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    mem_w_n_d    = 1'b1;
    mem_ad_wr_d  = mem_ad_wr_q;
    mem_dl_d     = mem_dl_q;
    mem_dh_d     = mem_dh_q;
    beat1_d      = beat1_q;
    beat1_pend_d = 1'b0;
    wr_words_d   = wr_words_q;
    mem_filled_d = mem_filled_q;

    if (state_q == ST_IDLE && cal_done) state_d = ST_RUN;

    if (beat1_pend_q) {mem_dh_d, mem_dl_d} = beat1_q;

    if (issue) begin
      mem_w_n_d             = 1'b0;
      mem_ad_wr_d           = addr_q;
      {mem_dh_d, mem_dl_d}  = buf_beat0;
      if (NW > 1) begin
        beat1_d      = buf_beat1;
        beat1_pend_d = 1'b1;
      end
      wr_words_d = sat_add_nw(wr_words_q);
      if (addr_q == ADDR_HI) begin
        mem_filled_d = 1'b1;
`ifdef FIFO_TO_MEM_WRAP_EN
        addr_d = ADDR_LO;
`else
        state_d = ST_FULL;
`endif
      end else begin
        addr_d = addr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_any) begin
      state_q      <= ST_IDLE;
      addr_q       <= ADDR_LO;
      mem_w_n_q    <= 1'b1;
      mem_ad_wr_q  <= ADDR_LO;
      mem_dl_q     <= '0;
      mem_dh_q     <= '0;
      beat1_pend_q <= 1'b0;
      wr_words_q   <= '0;
      mem_filled_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      mem_w_n_q    <= mem_w_n_d;
      mem_ad_wr_q  <= mem_ad_wr_d;
      mem_dl_q     <= mem_dl_d;
      mem_dh_q     <= mem_dh_d;
      beat1_pend_q <= beat1_pend_d;
      wr_words_q   <= wr_words_d;
      mem_filled_q <= mem_filled_d;
    end
  end

  always_ff @(posedge clk) begin
    beat1_q <= beat1_d;
  end

  assign mem_w_n    = mem_w_n_q;
  assign mem_ad_wr  = mem_ad_wr_q;
  assign mem_dl     = mem_dl_q;
  assign mem_dh     = mem_dh_q;
  assign mem_bw_n   = '0;
  assign wr_words   = wr_words_q;
  assign mem_filled = mem_filled_q;

endmodule

// File: tb/tb_fifo_to_mem.sv
// Directed bench for fifo_to_mem: BL2, BL4 and a 4-address BL2 instance share
// one FIFO model; one instance is active (sel) at a time.
module tb_fifo_to_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sw_rst, cal_a, cal_b, cal_c, mem_wr_full;
  logic fifo_empty;
  logic [71:0] fifo_data = '0;
  logic [71:0] fmem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int sel = 0;

  logic a_rd, a_wn, a_filled; logic [18:0] a_ad; logic [35:0] a_dl, a_dh; logic [3:0] a_bw; logic [19:0] a_words;
  logic b_rd, b_wn, b_filled; logic [18:0] b_ad; logic [35:0] b_dl, b_dh; logic [3:0] b_bw; logic [19:0] b_words;
  logic c_rd, c_wn, c_filled; logic [3:0]  c_ad; logic [35:0] c_dl, c_dh; logic [3:0] c_bw; logic [4:0]  c_words;

  fifo_to_mem #(.MEM_BURST_LENGTH(2)) dut_a (
    .clk(clk), .rst(rst), .sw_rst(sw_rst), .cal_done(cal_a), .fifo_empty(fifo_empty),
    .fifo_rd_en(a_rd), .fifo_data(fifo_data), .mem_wr_full(mem_wr_full), .mem_w_n(a_wn),
    .mem_ad_wr(a_ad), .mem_dl(a_dl), .mem_dh(a_dh), .mem_bw_n(a_bw), .wr_words(a_words),
    .mem_filled(a_filled));

  fifo_to_mem #(.MEM_BURST_LENGTH(4)) dut_b (
    .clk(clk), .rst(rst), .sw_rst(sw_rst), .cal_done(cal_b), .fifo_empty(fifo_empty),
    .fifo_rd_en(b_rd), .fifo_data(fifo_data), .mem_wr_full(mem_wr_full), .mem_w_n(b_wn),
    .mem_ad_wr(b_ad), .mem_dl(b_dl), .mem_dh(b_dh), .mem_bw_n(b_bw), .wr_words(b_words),
    .mem_filled(b_filled));

  fifo_to_mem #(.MEM_ADDR_WIDTH(4), .MEM_BURST_LENGTH(2), .MEM_ADDR_LOW(0), .MEM_ADDR_HIGH(3)) dut_c (
    .clk(clk), .rst(rst), .sw_rst(sw_rst), .cal_done(cal_c), .fifo_empty(fifo_empty),
    .fifo_rd_en(c_rd), .fifo_data(fifo_data), .mem_wr_full(mem_wr_full), .mem_w_n(c_wn),
    .mem_ad_wr(c_ad), .mem_dl(c_dl), .mem_dh(c_dh), .mem_bw_n(c_bw), .wr_words(c_words),
    .mem_filled(c_filled));

  // Standard (non-FWFT) FIFO: data appears the cycle after the pop.
  logic sel_rd;
  always_comb begin
    case (sel)
      0:       sel_rd = a_rd;
      1:       sel_rd = b_rd;
      default: sel_rd = c_rd;
    endcase
  end
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (sel_rd && rd_ptr != wr_ptr) begin
      fifo_data <= fmem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Command log of the active instance, with the following cycle as beat 1.
  logic [31:0] log_ad [64];
  logic [35:0] log_dh [64], log_dl [64], log_b1h [64], log_b1l [64];
  logic        log_b1wn [64];
  int   n_cmd = 0;
  logic prev_cmd = 1'b0;
  always @(negedge clk) begin
    logic wn; logic [31:0] ad; logic [35:0] dh, dl;
    case (sel)
      0:       begin wn = a_wn; ad = 32'(a_ad); dh = a_dh; dl = a_dl; end
      1:       begin wn = b_wn; ad = 32'(b_ad); dh = b_dh; dl = b_dl; end
      default: begin wn = c_wn; ad = 32'(c_ad); dh = c_dh; dl = c_dl; end
    endcase
    if (prev_cmd && n_cmd > 0) begin
      log_b1h[n_cmd-1] = dh; log_b1l[n_cmd-1] = dl; log_b1wn[n_cmd-1] = wn;
    end
    if (!wn && n_cmd < 64) begin
      log_ad[n_cmd] = ad; log_dh[n_cmd] = dh; log_dl[n_cmd] = dl;
      n_cmd = n_cmd + 1;
    end
    prev_cmd = !wn;
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [35:0] dh;
    logic [35:0] dl;
    logic [35:0] b1h;
    logic [35:0] b1l;
  } vec_t;
  vec_t t1 [8];
  vec_t t2 [3];
  int   t4_ad [6];

  task automatic nclk();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] word(input int n);
    return {36'h100000000 + 36'(n), 36'(n)};
  endfunction

  task automatic push_words(input int first, input int count);
    for (int i = 0; i < count; i++) begin
      fmem[wr_ptr[7:0]] = word(first + i);
      wr_ptr++;
    end
  endtask

  task automatic wait_cmds(input int target, input int budget, input string name);
    int cyc;
    cyc = 0;
    while (n_cmd < target && cyc < budget) begin
      nclk();
      cyc++;
    end
    total++;
    if (n_cmd < target) begin
      bad++;
      $display("FAIL %s timeout: got %0d commands expected %0d", name, n_cmd, target);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nclk();
    nclk();
    rst = 1'b0;
    nclk();
  endtask

  initial begin
    int base, p0, hb, found, cyc;
    rst = 1'b1; sw_rst = 1'b0; cal_a = 1'b0; cal_b = 1'b0; cal_c = 1'b0; mem_wr_full = 1'b0;

    t1[0] = '{32'd0, 36'h100000001, 36'h000000001, 36'h0, 36'h0};
    t1[1] = '{32'd1, 36'h100000002, 36'h000000002, 36'h0, 36'h0};
    t1[2] = '{32'd2, 36'h100000003, 36'h000000003, 36'h0, 36'h0};
    t1[3] = '{32'd3, 36'h100000004, 36'h000000004, 36'h0, 36'h0};
    t1[4] = '{32'd4, 36'h100000005, 36'h000000005, 36'h0, 36'h0};
    t1[5] = '{32'd5, 36'h100000006, 36'h000000006, 36'h0, 36'h0};
    t1[6] = '{32'd6, 36'h100000007, 36'h000000007, 36'h0, 36'h0};
    t1[7] = '{32'd7, 36'h100000008, 36'h000000008, 36'h0, 36'h0};
    t2[0] = '{32'd0, 36'h100000011, 36'h000000011, 36'h100000012, 36'h000000012};
    t2[1] = '{32'd1, 36'h100000013, 36'h000000013, 36'h100000014, 36'h000000014};
    t2[2] = '{32'd2, 36'h100000015, 36'h000000015, 36'h100000016, 36'h000000016};
`ifdef FIFO_TO_MEM_WRAP_EN
    t4_ad = '{0, 1, 2, 3, 0, 1};
`else
    t4_ad = '{0, 1, 2, 3, 0, 0};
`endif

    nclk(); nclk();
    rst = 1'b0;
    nclk();

    // reset state
    chk("rst_rd_en",  72'(a_rd), 72'd0);
    chk("rst_w_n",    72'(a_wn), 72'd1);
    chk("rst_ad",     72'(a_ad), 72'd0);
    chk("rst_dl",     72'(a_dl), 72'd0);
    chk("rst_dh",     72'(a_dh), 72'd0);
    chk("rst_words",  72'(a_words), 72'd0);
    chk("rst_filled", 72'(a_filled), 72'd0);
    chk("rst_bw_n",   72'(a_bw), 72'd0);

    // BL2 streaming, 8 words
    base = n_cmd;
    push_words(1, 8);
    cal_a = 1'b1;
    wait_cmds(base + 8, 200, "t1_cmds");
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_ad%0d", i), 72'(log_ad[base+i]), 72'(t1[i].addr));
      chk($sformatf("t1_dh%0d", i), 72'(log_dh[base+i]), 72'(t1[i].dh));
      chk($sformatf("t1_dl%0d", i), 72'(log_dl[base+i]), 72'(t1[i].dl));
    end
    chk("t1_words", 72'(a_words), 72'd8);
    chk("t1_filled", 72'(a_filled), 72'd0);

    // no calibration: nothing moves; then first command within 3 cycles
    cal_a = 1'b0;
    do_reset();
    base = n_cmd;
    push_words(16'h41, 2);
    for (int i = 0; i < 20; i++) begin
      nclk();
      chk("t5_idle", 72'({a_rd, a_wn}), 72'b01);
    end
    cal_a = 1'b1;
    found = 0;
    for (int i = 0; i < 3; i++) begin
      nclk();
      if (!a_wn && found == 0) found = i + 1;
    end
    chk("t5_first_cmd_in_3", 72'(found != 0), 72'd1);
    wait_cmds(base + 2, 50, "t5_cmds");
    chk("t5_ad0", 72'(log_ad[base]), 72'd0);
    chk("t5_dl0", 72'(log_dl[base]), 72'h41);

    // write queue full for 10 cycles mid-stream
    do_reset();
    base = n_cmd;
    push_words(16'h21, 6);
    wait_cmds(base + 2, 50, "t3_pre");
    mem_wr_full = 1'b1;
    p0 = rd_ptr;
    nclk();
    hb = n_cmd;
    for (int i = 0; i < 9; i++) nclk();
    chk("t3_hold_cmds", 72'(n_cmd - hb), 72'd0);
    chk("t3_hold_pops_le_nw", 72'((rd_ptr - p0) <= 1), 72'd1);
    mem_wr_full = 1'b0;
    wait_cmds(base + 6, 100, "t3_cmds");
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t3_ad%0d", i), 72'(log_ad[base+i]), 72'(i));
      chk($sformatf("t3_dh%0d", i), 72'(log_dh[base+i]), 72'(36'h100000021 + 36'(i)));
    end
    chk("t3_words", 72'(a_words), 72'd6);
    cal_a = 1'b0;

    // BL4: 6 words -> 3 bursts with beat 1 on the following cycle
    sel = 1;
    do_reset();
    cal_b = 1'b1;
    base = n_cmd;
    push_words(16'h11, 6);
    wait_cmds(base + 3, 200, "t2_cmds");
    nclk();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2_ad%0d", i),  72'(log_ad[base+i]),  72'(t2[i].addr));
      chk($sformatf("t2_dh%0d", i),  72'(log_dh[base+i]),  72'(t2[i].dh));
      chk($sformatf("t2_dl%0d", i),  72'(log_dl[base+i]),  72'(t2[i].dl));
      chk($sformatf("t2_b1h%0d", i), 72'(log_b1h[base+i]), 72'(t2[i].b1h));
      chk($sformatf("t2_b1l%0d", i), 72'(log_b1l[base+i]), 72'(t2[i].b1l));
      chk($sformatf("t2_b1wn%0d", i), 72'(log_b1wn[base+i]), 72'd1);
    end
    chk("t2_words", 72'(b_words), 72'd6);

    // sw_rst during beat 1 of a BL4 burst
    push_words(16'h51, 2);
    cyc = 0;
    while (b_wn && cyc < 50) begin
      nclk();
      cyc++;
    end
    chk("t6_cmd_seen", 72'(b_wn), 72'd0);
    chk("t6_cmd_ad", 72'(b_ad), 72'd3);
    nclk();
    chk("t6_beat1_wn", 72'(b_wn), 72'd1);
    sw_rst = 1'b1;
    nclk();
    chk("t6_rst_rd_en",  72'(b_rd), 72'd0);
    chk("t6_rst_w_n",    72'(b_wn), 72'd1);
    chk("t6_rst_ad",     72'(b_ad), 72'd0);
    chk("t6_rst_dl",     72'(b_dl), 72'd0);
    chk("t6_rst_dh",     72'(b_dh), 72'd0);
    chk("t6_rst_words",  72'(b_words), 72'd0);
    chk("t6_rst_filled", 72'(b_filled), 72'd0);
    sw_rst = 1'b0;
    base = n_cmd;
    push_words(16'h61, 2);
    wait_cmds(base + 1, 50, "t6_restart");
    chk("t6_restart_ad", 72'(log_ad[base]), 72'd0);
    chk("t6_restart_dh", 72'(log_dh[base]), 72'h100000061);
    cal_b = 1'b0;

    // 4-address range, 6 words
    sel = 2;
    do_reset();
    cal_c = 1'b1;
    base = n_cmd;
    push_words(16'h31, 6);
`ifdef FIFO_TO_MEM_WRAP_EN
    wait_cmds(base + 6, 100, "t4_cmds");
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t4_ad%0d", i), 72'(log_ad[base+i]), 72'(t4_ad[i]));
      chk($sformatf("t4_dl%0d", i), 72'(log_dl[base+i]), 72'(36'h31 + 36'(i)));
    end
    chk("t4_words", 72'(c_words), 72'd6);
`else
    wait_cmds(base + 4, 100, "t4_cmds");
    for (int i = 0; i < 10; i++) begin
      nclk();
      chk("t4_no_pop", 72'(c_rd), 72'd0);
    end
    chk("t4_cmd_count", 72'(n_cmd - base), 72'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_ad%0d", i), 72'(log_ad[base+i]), 72'(t4_ad[i]));
      chk($sformatf("t4_dl%0d", i), 72'(log_dl[base+i]), 72'(36'h31 + 36'(i)));
    end
    chk("t4_words", 72'(c_words), 72'd4);
    wr_ptr = rd_ptr;
`endif
    chk("t4_filled", 72'(c_filled), 72'd1);
    cal_c = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
